// File: rtl/mailbox_monitor.sv
// mailbox_monitor: 16-byte memory-mapped mailbox with a completion flag,
// a result word, a free-running cycle counter and a watchdog.
// Register map (addr_i[3:2]): 0 FLAG (RW), 1 RESULT (RW), 2 CYCLES (RO),
// 3 STATUS (RO: bit0 done, bit1 timeout).
// Optional macro MAILBOX_DISPLAY_EN: when defined, simulation prints
// "result: <RESULT>" on completion and "timeout" on watchdog expiry.
//
// Bus handshake: gnt_o mirrors req_i (no back-pressure). Every granted
// request gets exactly one response, rvalid_o high for one cycle on the
// following cycle, with rdata_o/err_o valid only while rvalid_o is high
// (rdata_o is forced to zero otherwise).
//
// The FSM state is kept in the enumerated register state_q so checkers can
// bind to it directly.
module mailbox_monitor #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DONE    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    localparam logic [1:0] REG_FLAG   = 2'd0;
    localparam logic [1:0] REG_RESULT = 2'd1;
    localparam logic [1:0] REG_CYCLES = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    state_e      state_q, state_d;
    logic [31:0] flag_q, flag_d;
    logic [31:0] result_q, result_d;
    logic [31:0] cycles_q, cycles_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        in_window;
    logic [1:0]  reg_sel;
    logic        wr_ok;
    logic        flag_set;
    logic        wdog_hit;
    logic [31:0] rd_word;

    // Byte lanes of addr_i are irrelevant to a word-wide register file.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    // Merge write data into the old value under the byte enables.
    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign gnt_o     = req_i;
    assign in_window = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = addr_i[3:2];
    assign wr_ok     = req_i && we_i && in_window;

    // Register-file updates, cycle counter and watchdog compare.
    always_comb begin
        flag_d   = flag_q;
        result_d = result_q;
        cycles_d = cycles_q;
        if (wr_ok && (reg_sel == REG_FLAG))   flag_d   = apply_be(flag_q, wdata_i, be_i);
        if (wr_ok && (reg_sel == REG_RESULT)) result_d = apply_be(result_q, wdata_i, be_i);
        if ((state_q == ST_RUN) && (cycles_q != 32'hFFFF_FFFF)) cycles_d = cycles_q + 32'd1;
        // Completion is judged on the value the write leaves behind.
        flag_set = wr_ok && (reg_sel == REG_FLAG) && flag_d[0];
        // Compare the next count so timeout asserts on the edge CYCLES reaches the limit.
        wdog_hit = (MAX_CYCLES != 32'd0) && (cycles_d == MAX_CYCLES);
    end

    // Next-state logic: completion takes priority over a simultaneous watchdog hit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flag_set)      state_d = ST_DONE;
                else if (wdog_hit) state_d = ST_TIMEOUT;
            end
            ST_DONE:    state_d = ST_DONE;
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_RUN;
        endcase
    end

    // FSM outputs decoded from the current state only.
    always_comb begin
        done_o    = (state_q == ST_DONE);
        timeout_o = (state_q == ST_TIMEOUT);
    end

    // Read mux and response generation, sampled at the acceptance cycle.
    always_comb begin
        rd_word = 32'd0;
        case (reg_sel)
            REG_FLAG:   rd_word = flag_q;
            REG_RESULT: rd_word = result_q;
            REG_CYCLES: rd_word = cycles_q;
            REG_STATUS: rd_word = {30'd0, state_q == ST_TIMEOUT, state_q == ST_DONE};
            default:    rd_word = 32'd0;
        endcase
        rvalid_d = req_i;
        err_d    = req_i && !in_window;
        rdata_d  = (req_i && !we_i && in_window) ? rd_word : 32'd0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Datapath and response registers; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q   <= 32'd0;
            result_q <= 32'd0;
            cycles_q <= 32'd0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            flag_q   <= flag_d;
            result_q <= result_d;
            cycles_q <= cycles_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
    assign result_o = result_q;

`ifdef MAILBOX_DISPLAY_EN
    // Announce the terminal transition exactly once.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == ST_RUN)) begin
            if (state_d == ST_DONE)         $display("result: %0d", result_q);
            else if (state_d == ST_TIMEOUT) $display("timeout");
        end
    end
`else
`endif

endmodule

// File: doc/mailbox_monitor.md
MAILBOX_MONITOR -- requirements
Module: mailbox_monitor

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: word-aligned base of the 16-byte register window.
REQ-002 Parameter MAX_CYCLES, default 32'd100000: watchdog limit in cycles; 0 disables the watchdog.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 req_i  input  1: data-bus request from core.
REQ-006 gnt_o  output  1: request accepted this cycle.
REQ-007 rvalid_o  output  1: response valid, one per accepted request.
REQ-008 addr_i  input  32: byte address.
REQ-009 we_i  input  1: 1 = write, 0 = read.
REQ-010 be_i  input  4: byte enables for writes.
REQ-011 wdata_i  input  32: write data.
REQ-012 rdata_o  output  32: read data, valid with rvalid_o.
REQ-013 err_o  output  1: response error, valid with rvalid_o.
REQ-014 done_o  output  1: program signalled completion.
REQ-015 timeout_o  output  1: watchdog expired before completion.
REQ-016 result_o  output  32: latched result word.

Function
REQ-017 Register map (offset addr_i[3:2]): 0 FLAG (RW), 1 RESULT (RW), 2 CYCLES (RO), 3 STATUS (RO: bit0 done, bit1 timeout, others 0).
REQ-018 gnt_o = req_i combinationally; no back-pressure; back-to-back requests accepted every cycle.
REQ-019 rvalid_o asserted exactly one cycle after each accepted request; rdata_o/err_o registered with it; rdata_o = 0 when rvalid_o low.
REQ-020 In-window test: addr_i[31:4] == BASE_ADDR[31:4]; out-of-window access -> err_o=1, rdata_o=0, no state change.
REQ-021 Writes apply be_i per byte; write to CYCLES or STATUS ignored, err_o=0.
REQ-022 State machine RUN -> DONE when accepted write leaves FLAG[0]=1; RUN -> TIMEOUT when CYCLES reaches MAX_CYCLES (MAX_CYCLES != 0); DONE and TIMEOUT terminal until reset.
REQ-023 done_o=1 in DONE; timeout_o=1 in TIMEOUT; never both.
REQ-024 Same-cycle FLAG write and watchdog hit: DONE wins.
REQ-025 CYCLES increments by 1 each cycle in RUN, frozen in DONE/TIMEOUT, saturates at 32'hFFFF_FFFF.
REQ-026 Read and write same register in consecutive cycles: read returns post-write value; read of CYCLES returns value sampled at acceptance cycle.
REQ-027 result_o mirrors RESULT register continuously; writes to RESULT in DONE/TIMEOUT still accepted.

Reset
REQ-028 rst_n low: FLAG=0, RESULT=0, CYCLES=0, state=RUN, gnt_o follows req_i, rvalid_o=0, rdata_o=0, err_o=0, done_o=0, timeout_o=0.
REQ-029 Reset during pending response: response dropped, no rvalid_o after deassertion.

Configuration
REQ-030 Macro MAILBOX_DISPLAY_EN defined: on RUN->DONE, simulation prints "result: <decimal RESULT>" once and on TIMEOUT prints "timeout"; not defined: no simulation-only constructs compiled, synthesizable behaviour identical.

Verification
REQ-031 Write 32'd55 to BASE+4, then 32'd1 to BASE+0 -> next cycle done_o=1, result_o=55, STATUS read returns 32'h1.
REQ-032 Three back-to-back reads BASE+0/+4/+8 -> rvalid_o high three consecutive cycles, err_o=0, data in order.
REQ-033 MAX_CYCLES=20, no FLAG write -> timeout_o=1 at cycle 20 after reset release, CYCLES frozen at 20, done_o stays 0.
REQ-034 Write 32'hFFFF_FFFF with be_i=4'b0010 to BASE+4 -> RESULT=32'h0000_FF00; write to BASE+8 -> CYCLES unchanged, err_o=0.
REQ-035 Read BASE+16 -> err_o=1, rdata_o=0; rst_n pulsed low one cycle after a request -> no rvalid_o, all outputs at reset values.
